// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback and drives the datapath and memory handshake.
// Optional feature macro: MCTRL_BNE_EN adds bne (opcode 000101) as a BRANCH variant taken on ~zero.
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_write,
    output logic       o_iord,
    output logic       o_ir_write,
    output logic       o_pc_en,
    output logic [1:0] o_pc_src,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [3:0] o_alu_ctrl,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_illegal,
    output logic       o_bus_err
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPE_EX, S_ALUWB, S_BRANCH, S_ADDI_EX, S_ADDI_WB, S_JUMP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_is_mem;
    logic             w_timeout;
    logic             w_funct_ok;
    logic [3:0]       w_funct_alu;
    logic             w_br_taken;

    assign w_is_mem  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout = w_is_mem && !i_mem_ready && (r_wait_cnt == CNT_LAST);

`ifdef MCTRL_BNE_EN
    assign w_br_taken = (i_opcode == OP_BNE) ? ~i_zero : i_zero;
`else
    assign w_br_taken = i_zero;
`endif

    // R-type funct to ALU operation
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_ADD;
        case (i_funct)
            6'b100000: w_funct_alu = ALU_ADD;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b101010: w_funct_alu = ALU_SLT;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            // Counts unanswered cycles in a mem state; cleared everywhere else
            if (w_is_mem && !i_mem_ready && !w_timeout) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else                                        r_wait_cnt <= '0;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_mem_req    = 1'b0;
        o_mem_write  = 1'b0;
        o_iord       = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_en      = 1'b0;
        o_pc_src     = 2'b00;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'b00;
        o_alu_ctrl   = ALU_ADD;
        o_reg_write  = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_illegal    = 1'b0;
        o_bus_err    = w_timeout;
        case (r_state)
            S_IDLE: begin
                o_alu_ctrl = ALU_AND;
                w_next     = S_FETCH;
            end
            S_FETCH: begin
                o_mem_req   = 1'b1;
                o_alu_src_b = 2'b01;
                o_ir_write  = i_mem_ready;
                o_pc_en     = i_mem_ready;
                if (i_mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                o_alu_src_b = 2'b11;
                case (i_opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE: begin
                        if (w_funct_ok) w_next = S_RTYPE_EX;
                        else begin
                            o_illegal = 1'b1;
                            w_next    = S_FETCH;
                        end
                    end
                    OP_BEQ:  w_next = S_BRANCH;
`ifdef MCTRL_BNE_EN
                    OP_BNE:  w_next = S_BRANCH;
`endif
                    OP_ADDI: w_next = S_ADDI_EX;
                    OP_J:    w_next = S_JUMP;
                    default: begin
                        o_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                w_next      = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
                if (i_mem_ready)    w_next = S_MEMWB;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                o_mem_req   = 1'b1;
                o_mem_write = 1'b1;
                o_iord      = 1'b1;
                if (i_mem_ready || w_timeout) w_next = S_FETCH;
            end
            S_RTYPE_EX: begin
                o_alu_src_a = 1'b1;
                o_alu_ctrl  = w_funct_alu;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_ctrl  = ALU_SUB;
                o_pc_src    = 2'b01;
                o_pc_en     = w_br_taken;
                w_next      = S_FETCH;
            end
            S_ADDI_EX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                w_next      = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                o_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                o_pc_src = 2'b10;
                o_pc_en  = 1'b1;
                w_next   = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: inputs change on the falling edge, outputs are checked 1 time unit later.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic       reg_write, reg_dst, mem_to_reg, illegal, bus_err;
    logic [18:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_opcode(opcode), .i_funct(funct), .i_zero(zero), .i_mem_ready(mem_ready),
        .o_mem_req(mem_req), .o_mem_write(mem_write), .o_iord(iord), .o_ir_write(ir_write),
        .o_pc_en(pc_en), .o_pc_src(pc_src), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
        .o_alu_ctrl(alu_ctrl), .o_reg_write(reg_write), .o_reg_dst(reg_dst),
        .o_mem_to_reg(mem_to_reg), .o_illegal(illegal), .o_bus_err(bus_err)
    );

    assign outs = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                   alu_ctrl, reg_write, reg_dst, mem_to_reg, illegal, bus_err};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, drive mem_ready, let outputs settle
    task automatic nxt(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        #2;
        chk("reset_outs", 32'(outs), 32'h0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("idle_outs", 32'(outs), 32'h0);

        // lw with two wait cycles on each memory access
        opcode = 6'b100011;
        nxt(1'b0);
        chk("f_req", 32'(mem_req), 32'd1);
        chk("f_iord", 32'(iord), 32'd0);
        chk("f_srcb", 32'(alu_src_b), 32'd1);
        chk("f_alu", 32'(alu_ctrl), 32'h2);
        chk("f_irw_wait", 32'(ir_write), 32'd0);
        chk("f_pcen_wait", 32'(pc_en), 32'd0);
        nxt(1'b0);
        chk("f_irw_wait2", 32'(ir_write), 32'd0);
        nxt(1'b1);
        chk("f_irw_rdy", 32'(ir_write), 32'd1);
        chk("f_pcen_rdy", 32'(pc_en), 32'd1);
        nxt(1'b0);
        chk("dec_srcb", 32'(alu_src_b), 32'd3);
        chk("dec_illegal", 32'(illegal), 32'd0);
        nxt(1'b0);
        chk("madr_srca", 32'(alu_src_a), 32'd1);
        chk("madr_srcb", 32'(alu_src_b), 32'd2);
        nxt(1'b0);
        chk("mrd_req", 32'(mem_req), 32'd1);
        chk("mrd_iord", 32'(iord), 32'd1);
        chk("mrd_regw", 32'(reg_write), 32'd0);
        nxt(1'b0);
        chk("mrd_wait_req", 32'(mem_req), 32'd1);
        nxt(1'b1);
        chk("mrd_rdy_req", 32'(mem_req), 32'd1);
        nxt(1'b0);
        chk("mwb_regw", 32'(reg_write), 32'd1);
        chk("mwb_m2r", 32'(mem_to_reg), 32'd1);
        chk("mwb_dst", 32'(reg_dst), 32'd0);

        // beq, taken then not-taken on the same BRANCH cycle
        opcode = 6'b000100;
        nxt(1'b1);
        chk("beq_fetch", 32'(mem_req), 32'd1);
        nxt(1'b0);
        zero = 1'b1;
        nxt(1'b0);
        chk("br_pcen_z1", 32'(pc_en), 32'd1);
        chk("br_pcsrc", 32'(pc_src), 32'd1);
        chk("br_alu", 32'(alu_ctrl), 32'h6);
        zero = 1'b0; #1;
        chk("br_pcen_z0", 32'(pc_en), 32'd0);

        // R-type SLT
        opcode = 6'b000000; funct = 6'b101010;
        nxt(1'b1);
        nxt(1'b0);
        chk("rt_dec_illegal", 32'(illegal), 32'd0);
        nxt(1'b0);
        chk("rt_ex_alu", 32'(alu_ctrl), 32'h7);
        chk("rt_ex_srca", 32'(alu_src_a), 32'd1);
        chk("rt_ex_srcb", 32'(alu_src_b), 32'd0);
        nxt(1'b0);
        chk("rt_wb_regw", 32'(reg_write), 32'd1);
        chk("rt_wb_dst", 32'(reg_dst), 32'd1);

        // R-type with unsupported funct
        funct = 6'b000000;
        nxt(1'b1);
        nxt(1'b0);
        chk("badfn_illegal", 32'(illegal), 32'd1);
        chk("badfn_regw", 32'(reg_write), 32'd0);

        // FETCH with mem_ready stuck low: bus_err on the 16th cycle only
        for (int i = 1; i <= 16; i++) begin
            nxt(1'b0);
            chk($sformatf("to_buserr_%0d", i), 32'(bus_err), (i == 16) ? 32'd1 : 32'd0);
            chk($sformatf("to_req_%0d", i), 32'(mem_req), 32'd1);
        end
        chk("to_irw", 32'(ir_write), 32'd0);
        chk("to_pcen", 32'(pc_en), 32'd0);
        nxt(1'b0);
        chk("to_refetch_req", 32'(mem_req), 32'd1);
        chk("to_refetch_iord", 32'(iord), 32'd0);
        chk("to_refetch_buserr", 32'(bus_err), 32'd0);

        // opcode 000101
        opcode = 6'b000101; zero = 1'b0;
        nxt(1'b1);
        nxt(1'b0);
`ifdef MCTRL_BNE_EN
        chk("bne_dec_illegal", 32'(illegal), 32'd0);
        nxt(1'b0);
        chk("bne_pcen", 32'(pc_en), 32'd1);
        chk("bne_pcsrc", 32'(pc_src), 32'd1);
        zero = 1'b1; #1;
        chk("bne_pcen_z1", 32'(pc_en), 32'd0);
        zero = 1'b0;
`else
        chk("bne_dec_illegal", 32'(illegal), 32'd1);
        chk("bne_dec_pcen", 32'(pc_en), 32'd0);
        nxt(1'b0);
        chk("bne_refetch_req", 32'(mem_req), 32'd1);
        chk("bne_refetch_pcen", 32'(pc_en), 32'd0);
        mem_ready = 1'b1; #1;
        chk("bne_refetch_rdy_irw", 32'(ir_write), 32'd1);
`endif

        // sw
        opcode = 6'b101011;
`ifdef MCTRL_BNE_EN
        nxt(1'b1);
`endif
        nxt(1'b0);
        nxt(1'b0);
        nxt(1'b1);
        chk("sw_req", 32'(mem_req), 32'd1);
        chk("sw_write", 32'(mem_write), 32'd1);
        chk("sw_iord", 32'(iord), 32'd1);
        chk("sw_regw", 32'(reg_write), 32'd0);

        // j
        opcode = 6'b000010;
        nxt(1'b1);
        chk("j_fetch_req", 32'(mem_req), 32'd1);
        nxt(1'b0);
        nxt(1'b0);
        chk("j_pcen", 32'(pc_en), 32'd1);
        chk("j_pcsrc", 32'(pc_src), 32'd2);

        // addi
        opcode = 6'b001000;
        nxt(1'b1);
        nxt(1'b0);
        nxt(1'b0);
        chk("addi_ex_srcb", 32'(alu_src_b), 32'd2);
        chk("addi_ex_alu", 32'(alu_ctrl), 32'h2);
        nxt(1'b0);
        chk("addi_wb_regw", 32'(reg_write), 32'd1);
        chk("addi_wb_dst", 32'(reg_dst), 32'd0);
        chk("addi_wb_m2r", 32'(mem_to_reg), 32'd0);

        // lw interrupted by reset while in MEMRD
        opcode = 6'b100011;
        nxt(1'b1);
        nxt(1'b0);
        nxt(1'b0);
        nxt(1'b0);
        chk("rst_pre_iord", 32'(iord), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("rst_mid_outs", 32'(outs), 32'h0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst_idle_outs", 32'(outs), 32'h0);
        nxt(1'b0);
        chk("rst_fetch_req", 32'(mem_req), 32'd1);
        chk("rst_fetch_iord", 32'(iord), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
